// File: rtl/sid_audio_out.sv
// sid_audio_out: SID voice back end. Mixes three 12-bit voice samples with a
// single time-multiplexed adder, scales by a 4-bit master volume using a
// 4-step shift-add multiply, and plays the result as a 1-bit audio stream.
// A new mix is captured every frame of 2^PWM_BITS clocks. Each result is
// applied to the output one frame later, at a frame boundary.
// Optional build macro SID_SIGMA_DELTA_EN replaces the PWM comparator with a
// first-order sigma-delta modulator. Frame and mix timing are unchanged.
module sid_audio_out #(
  parameter int PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [11:0]         sample1,
  input  logic [11:0]         sample2,
  input  logic [11:0]         sample3,
  input  logic [3:0]          volume,
  input  logic                voice3_off,
  output logic [PWM_BITS-1:0] level,
  output logic                mix_valid,
  output logic                pwm_out
);

  typedef enum logic [3:0] {
    IDLE, SUM1, SUM2, SUM3, MUL0, MUL1, MUL2, MUL3, DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [PWM_BITS-1:0] counter_reg;
  logic [11:0]         s1_reg, s2_reg, s3_reg;
  logic [3:0]          vol_reg;
  logic                v3off_reg;
  logic [13:0]         acc_reg;
  logic [17:0]         prod_reg;
  logic [PWM_BITS-1:0] result_reg;
  logic [PWM_BITS-1:0] level_reg;
  logic                pwm_reg;

  // Shared adder operands, steered by the mix FSM
  logic [17:0] add_a, add_b, add_sum;
  logic [1:0]  mul_idx;
  logic        capture;
  logic [17:0] acc_ext;

  assign add_sum = add_a + add_b;
  assign acc_ext = {4'b0, acc_reg};

  // Mix FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic, adder operand selection and the mix_valid pulse
  always_comb begin
    state_next = state_reg;
    mix_valid  = 1'b0;
    capture    = 1'b0;
    add_a      = '0;
    add_b      = '0;
    mul_idx    = 2'd0;
    case (state_reg)
      IDLE: begin
        if (counter_reg == '0) begin
          capture    = 1'b1;
          state_next = SUM1;
        end
      end
      SUM1: begin
        add_b      = {6'b0, s1_reg};
        state_next = SUM2;
      end
      SUM2: begin
        add_a      = acc_ext;
        add_b      = {6'b0, s2_reg};
        state_next = SUM3;
      end
      SUM3: begin
        add_a      = acc_ext;
        add_b      = v3off_reg ? 18'd0 : {6'b0, s3_reg};
        state_next = MUL0;
      end
      MUL0: begin mul_idx = 2'd0; state_next = MUL1; end
      MUL1: begin mul_idx = 2'd1; state_next = MUL2; end
      MUL2: begin mul_idx = 2'd2; state_next = MUL3; end
      MUL3: begin mul_idx = 2'd3; state_next = DONE; end
      DONE: begin
        mix_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // One volume bit per MUL step, LSB first: add acc shifted by bit weight
    if (state_reg == MUL0 || state_reg == MUL1 ||
        state_reg == MUL2 || state_reg == MUL3) begin
      add_a = prod_reg;
      add_b = vol_reg[mul_idx] ? (acc_ext << mul_idx) : 18'd0;
    end
  end

  // Mix datapath: input capture, accumulate, multiply, latch result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg     <= '0;
      s2_reg     <= '0;
      s3_reg     <= '0;
      vol_reg    <= '0;
      v3off_reg  <= 1'b0;
      acc_reg    <= '0;
      prod_reg   <= '0;
      result_reg <= '0;
    end else begin
      if (capture) begin
        s1_reg    <= sample1;
        s2_reg    <= sample2;
        s3_reg    <= sample3;
        vol_reg   <= volume;
        v3off_reg <= voice3_off;
        acc_reg   <= '0;
        prod_reg  <= '0;
      end
      case (state_reg)
        SUM1, SUM2, SUM3:       acc_reg    <= add_sum[13:0];
        MUL0, MUL1, MUL2, MUL3: prod_reg   <= add_sum;
        DONE:                   result_reg <= prod_reg[17 -: PWM_BITS];
        default: ;
      endcase
    end
  end

  // Frame counter and frame-boundary duty update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_reg <= '0;
      level_reg   <= '0;
    end else begin
      counter_reg <= counter_reg + 1'b1;
      if (counter_reg == '0) level_reg <= result_reg;
    end
  end

`ifdef SID_SIGMA_DELTA_EN
  // Sigma-delta: the residue register holds the low bits of the accumulator;
  // its carry bit is registered directly as pwm_out.
  logic [PWM_BITS-1:0] sd_acc_reg;
  logic [PWM_BITS:0]   sd_sum;
  assign sd_sum = {1'b0, sd_acc_reg} + {1'b0, level_reg};

  // First-order modulator: carry out of the running sum is the output bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_acc_reg <= '0;
      pwm_reg    <= 1'b0;
    end else begin
      sd_acc_reg <= sd_sum[PWM_BITS-1:0];
      pwm_reg    <= sd_sum[PWM_BITS];
    end
  end
`else
  // Comparator PWM: high while the frame counter is below the duty value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_reg <= 1'b0;
    else        pwm_reg <= (counter_reg < level_reg);
  end
`endif

  assign level   = level_reg;
  assign pwm_out = pwm_reg;

endmodule

// File: tb/tb_sid_audio_out.sv
// Directed self-checking bench for sid_audio_out with PWM_BITS = 10.
// Expected levels are hand-computed: ((s1+s2+s3') * volume) >> 8.
module tb_sid_audio_out;

  localparam int PB = 10;
  localparam int FRAME = 1 << PB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   sample1, sample2, sample3;
  logic [3:0]    volume;
  logic          voice3_off;
  logic [PB-1:0] level;
  logic          mix_valid;
  logic          pwm_out;

  int n_checks = 0;
  int n_fail   = 0;

  sid_audio_out #(.PWM_BITS(PB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample1    (sample1),
    .sample2    (sample2),
    .sample3    (sample3),
    .volume     (volume),
    .voice3_off (voice3_off),
    .level      (level),
    .mix_valid  (mix_valid),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  // Bench reference for the frame counter position
  logic [PB-1:0] model_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_cnt <= '0;
    else        model_cnt <= model_cnt + 1'b1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Step to the next negedge where the frame counter equals v
  task automatic wait_cnt(input int v);
    bit hit = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge clk);
      if (int'(model_cnt) == v) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check_eq("wait_cnt_timeout", 0, 1);
  endtask

  // Observe one full frame of pwm_out once the new level is in force
  task automatic measure(input int exp, input string tag);
    int ones = 0;
    int bad = 0;
    int tbad = 0;
    int prevc;
    bit prevp = 0;
    wait_cnt(2);
    for (int i = 0; i < FRAME; i++) begin
      ones += int'(pwm_out);
      prevc = (model_cnt == 0) ? FRAME - 1 : int'(model_cnt) - 1;
      if (pwm_out != (prevc < exp)) bad++;
      if (i > 0 && pwm_out == prevp) tbad++;
      prevp = pwm_out;
      @(negedge clk);
    end
    check_eq({tag, "_ones"}, ones, exp);
`ifdef SID_SIGMA_DELTA_EN
    if (exp == FRAME / 2) check_eq({tag, "_sd_toggle_errs"}, tbad, 0);
`else
    check_eq({tag, "_pwm_pattern_errs"}, bad, 0);
`endif
    $display("case %s: level=%0d ones=%0d", tag, level, ones);
  endtask

  task automatic run_case(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [3:0] vol,
                          input logic v3, input int exp, input int hold,
                          input string tag);
    sample1 = a; sample2 = b; sample3 = c; volume = vol; voice3_off = v3;
    wait_cnt(1);
    check_eq({tag, "_hold_level"}, int'(level), hold);
    wait_cnt(1);
    check_eq({tag, "_level"}, int'(level), exp);
    measure(exp, tag);
  endtask

  initial begin
    bit found = 0;
    rst_n = 1'b0;
    sample1 = 12'hFFF; sample2 = 12'hFFF; sample3 = 12'hFFF;
    volume = 4'd15; voice3_off = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_level", int'(level), 0);
    check_eq("reset_mix_valid", int'(mix_valid), 0);
    check_eq("reset_pwm", int'(pwm_out), 0);
    rst_n = 1'b1;

    // Full-scale mix: first capture at the counter-0 cycle right after reset
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (mix_valid) begin
        found = 1;
        break;
      end
    end
    check_eq("mix_valid_seen", int'(found), 1);
    check_eq("mix_valid_cnt", int'(model_cnt), 8);
    @(negedge clk);
    check_eq("mix_valid_one_cycle", int'(mix_valid), 0);
    check_eq("first_frame_level", int'(level), 0);
    wait_cnt(1);
    check_eq("fs_level", int'(level), 719);
    measure(719, "fs");

    // 8190*15>>8, 2048*8>>8, mute, 11916*11>>8, full scale again
    run_case(12'hFFF, 12'hFFF, 12'hFFF, 4'd15, 1'b1, 479, 719, "v3off");
    run_case(12'h800, 12'h000, 12'h000, 4'd8,  1'b0, 64,  479, "single");
    run_case(12'hFFF, 12'hFFF, 12'hFFF, 4'd0,  1'b0, 0,   64,  "mute");
    run_case(12'hFFF, 12'hFFF, 12'hE8E, 4'd11, 1'b0, 512, 0,   "half");
    run_case(12'hFFF, 12'hFFF, 12'hFFF, 4'd15, 1'b0, 719, 512, "fs2");

    // Asynchronous reset during MUL1, between clock edges
    wait_cnt(5);
    #2;
    check_eq("pre_rst_pwm", int'(pwm_out), 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_level", int'(level), 0);
    check_eq("async_rst_pwm", int'(pwm_out), 0);
    check_eq("async_rst_mix_valid", int'(mix_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(1);
    check_eq("rst_frame0_level", int'(level), 0);
    wait_cnt(1);
    check_eq("rst_frame1_level", int'(level), 719);
    $display("case async_reset: level=%0d", level);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
